shift_deser_rx: RTL

- Serial-to-parallel receiver, the receiving end of the team's serial shift-out path.
- Collects framed serial bits into WIDTH-bit words, LSB-first or MSB-first.
- Buffers completed words in a 2-entry output FIFO with a valid/ready handshake.
- Flags framing errors and overflow with sticky status bits; sits between the serial link and parallel consumer logic.

---
 rtl/shift_deser_pkg.sv | 26 ++
 rtl/shift_deser_fifo.sv | 64 ++++++
 rtl/shift_deser_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/shift_deser_pkg.sv
// Shared types and helpers for the serial deserialiser receiver.
//   state_e    : assembly FSM states
//   FIFO_DEPTH : output buffer depth
//   clog2()    : bit-count width for a given word width
package shift_deser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned FIFO_DEPTH = 2;

    // Smallest r with 2**r >= n; at least 1 so a counter always has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_deser_fifo.sv
// Two-entry first-in first-out word buffer. The head entry lives in its own
// flop so the consumer sees a registered word.
//   clk, clear_n       : clock, async active-low reset
//   push, push_data    : write request (ignored when full and not popping)
//   pop                : read request (ignored when empty)
//   head               : oldest word
//   full, empty        : occupancy status
module shift_deser_fifo
    import shift_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]      head_q, head_d;
    logic [WIDTH-1:0]      tail_q, tail_d;
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;

    // Pop first (tail slides to head), then place a push in the first free slot.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        vld_d  = vld_q;
        if (pop && vld_q[0]) begin
            head_d = tail_q;
            tail_d = '0;
            vld_d  = {1'b0, vld_q[1]};
        end
        if (push) begin
            if (!vld_d[0]) begin
                head_d   = push_data;
                vld_d[0] = 1'b1;
            end else if (!vld_d[1]) begin
                tail_d   = push_data;
                vld_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            vld_q  <= vld_d;
        end
    end

    assign head  = head_q;
    assign full  = vld_q[1];
    assign empty = ~vld_q[0];

endmodule

// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: assembles framed serial bits into WIDTH-bit
// words (LSB- or MSB-first), buffers them in a 2-entry FIFO, and reports
// frame restarts and dropped words through sticky flags.
//   clk, clear_n                 : clock, async active-low reset
//   s_valid, s_data, s_frame     : serial bit stream, s_frame marks bit 0
//   lsb_first                    : bit order, latched at frame start
//   m_data, m_valid, m_ready     : parallel word handshake
//   busy                         : word assembly in progress
//   frame_err, overflow, clr_err : sticky status and its clear pulse
module shift_deser_rx
    import shift_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_frame,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clr_err
);

    localparam int unsigned CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             order_q, order_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic             start;
    logic             store;
    logic             push;
    logic             pop;
    logic             frame_set;
    logic             ord;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    idx;
    logic             fifo_full;
    logic             fifo_empty;

    // Next-state, bit placement and flag update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        order_d   = order_q;
        start     = 1'b0;
        store     = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start = s_valid && s_frame;
            end
            ST_SHIFT: begin
                if (s_valid) begin
                    start     = s_frame;
                    frame_set = s_frame;
                    store     = !s_frame;
                end
            end
        endcase

        // A new frame uses the live lsb_first; a word in progress uses the latched one.
        ord = start ? lsb_first : order_q;
        pos = start ? '0 : cnt_q;
        idx = ord ? pos : (CW'(WIDTH - 1) - pos);

        if (start) begin
            sreg_d      = '0;
            sreg_d[idx] = s_data;
            order_d     = lsb_first;
            cnt_d       = CW'(1);
            state_d     = ST_SHIFT;
        end else if (store) begin
            sreg_d[idx] = s_data;
            if (cnt_q == CW'(WIDTH - 1)) begin
                push    = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Setting beats clearing in the same cycle.
        frame_err_d = frame_set | (frame_err_q & ~clr_err);
        overflow_d  = (push & fifo_full & ~pop) | (overflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            order_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            order_q     <= order_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pop = m_valid & m_ready;

    shift_deser_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .clear_n   (clear_n),
        .push      (push),
        .push_data (sreg_d),
        .pop       (pop),
        .head      (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid   = ~fifo_empty;
    assign busy      = (state_q == ST_SHIFT);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
